// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmit controller. It takes a parallel payload and sends it as a
//   serial frame: a start bit, DATA_WIDTH data bits (LSB first), an optional
//   parity bit and a stop bit. Each bit lasts one clock cycle. The parity value
//   comes from an external parity calculator, which this block loads with the
//   latched payload during the START cycle.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active low
//   p_data         in   parallel payload
//   data_valid     in   payload request; accepted in IDLE or on STOP exit
//   par_en         in   1 = insert a parity bit
//   par_typ        in   parity type, 0 = even, 1 = odd
//   par_bit        in   parity result from the parity calculator
//   par_data       out  latched payload for the parity calculator
//   par_data_valid out  one-cycle load strobe for the parity calculator
//   par_enable     out  latched par_en
//   par_type       out  latched par_typ
//   tx_out         out  serial line, idle high
//   busy           out  high while a frame is in progress
//
// Handshake: there is no ready signal. A payload is taken on any rising edge
// where data_valid is 1 and the FSM is in IDLE or leaving STOP. In every other
// state data_valid is ignored and is not queued; a requester watches busy.
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  par_bit,
    output logic [DATA_WIDTH-1:0] par_data,
    output logic                  par_data_valid,
    output logic                  par_enable,
    output logic                  par_type,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  accept;
    logic                  last_bit;

    assign last_bit = (bit_cnt == LAST_BIT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and payload acceptance
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (data_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = DATA;
            end
            DATA: begin
                if (last_bit) begin
                    state_nxt = par_enable ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                // Back-to-back frames: a pending request skips IDLE entirely.
                if (data_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode depends only on the current state (plus the selected
    // data/parity source), so reset drives the line high immediately.
    always_comb begin
        tx_out = 1'b1;
        busy   = 1'b1;
        case (state)
            IDLE: begin
                tx_out = 1'b1;
                busy   = 1'b0;
            end
            START:   tx_out = 1'b0;
            DATA:    tx_out = shift_reg[0];
            PARITY:  tx_out = par_bit;
            STOP:    tx_out = 1'b1;
            default: begin
                tx_out = 1'b1;
                busy   = 1'b0;
            end
        endcase
    end

    // Payload and frame-option latches; shift register for serialisation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg  <= '0;
            par_data   <= '0;
            par_enable <= 1'b0;
            par_type   <= 1'b0;
        end else if (accept) begin
            shift_reg  <= p_data;
            par_data   <= p_data;
            par_enable <= par_en;
            par_type   <= par_typ;
        end else if (state == DATA) begin
            shift_reg  <= shift_reg >> 1;
        end
    end

    // Bit counter: counts DATA cycles, cleared when DATA is left
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (state == DATA && !last_bit) begin
            bit_cnt <= bit_cnt + 1'b1;
        end else begin
            bit_cnt <= '0;
        end
    end

    // Registered on the accepting edge so the strobe covers exactly the START
    // cycle; the parity calculator then has its result ready before PARITY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_data_valid <= 1'b0;
        end else begin
            par_data_valid <= accept;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Directed testbench for uart_tx_ctrl with DATA_WIDTH = 8. A small behavioural
//   parity calculator answers the controller's load strobe. Expected serial
//   waveforms are hand-computed constants, written first-cycle-first.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] p_data;
    logic         data_valid;
    logic         par_en;
    logic         par_typ;
    logic         par_bit;
    logic [W-1:0] par_data;
    logic         par_data_valid;
    logic         par_enable;
    logic         par_type;
    logic         tx_out;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .p_data         (p_data),
        .data_valid     (data_valid),
        .par_en         (par_en),
        .par_typ        (par_typ),
        .par_bit        (par_bit),
        .par_data       (par_data),
        .par_data_valid (par_data_valid),
        .par_enable     (par_enable),
        .par_type       (par_type),
        .tx_out         (tx_out),
        .busy           (busy)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Parity calculator model: loads on the strobe, even parity XOR type
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else if (par_data_valid) begin
            par_bit <= (^par_data) ^ par_type;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a payload and let the accepting edge happen; afterwards the
    // bench sits in cycle 0 (START) of the new frame.
    task automatic start_frame(input logic [W-1:0] d, input logic pen,
                               input logic ptyp, input logic hold);
        p_data     = d;
        par_en     = pen;
        par_typ    = ptyp;
        data_valid = 1'b1;
        tick();
        if (!hold) data_valid = 1'b0;
    endtask

    // Check n cycles of a frame. exp_bits holds the line, first cycle in the
    // most significant of the n used bits. pulse_at >= 0 injects a spurious
    // request plus toggled parity options during that cycle.
    task automatic check_frame(input logic [10:0] exp_bits, input int n,
                               input int pulse_at, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s tx c%0d", tag, i), tx_out, exp_bits[n-1-i]);
            chk($sformatf("%s busy c%0d", tag, i), busy, 1'b1);
            chk($sformatf("%s pdv c%0d", tag, i), par_data_valid, (i == 0) ? 1'b1 : 1'b0);
            if (i == pulse_at) begin
                data_valid = 1'b1;
                p_data     = 8'hFF;
                par_en     = ~par_en;
                par_typ    = ~par_typ;
            end else if (pulse_at >= 0 && i == pulse_at + 1) begin
                data_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle tx"},   tx_out, 1'b1);
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle pdv"},  par_data_valid, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        data_valid = 1'b0;
        p_data     = '0;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst tx", tx_out, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst pdv", par_data_valid, 1'b0);
        chk("rst par_data", par_data, 8'h00);
        chk("rst par_enable", par_enable, 1'b0);
        chk("rst par_type", par_type, 1'b0);
        rst = 1'b1;
        tick();
        check_idle("post rst");

        // 0xA5, even parity
        start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("a5 par_data", par_data, 8'hA5);
        chk("a5 par_enable", par_enable, 1'b1);
        chk("a5 par_type", par_type, 1'b0);
        check_frame(11'b01010010101, 11, -1, "a5");
        check_idle("a5");

        // 0x01 odd parity -> parity slot 0
        start_frame(8'h01, 1'b1, 1'b1, 1'b0);
        check_frame(11'b01000000001, 11, -1, "01odd");
        check_idle("01odd");

        // 0x00 odd parity -> parity slot 1
        start_frame(8'h00, 1'b1, 1'b1, 1'b0);
        check_frame(11'b00000000011, 11, -1, "00odd");
        check_idle("00odd");

        // 0xFF without parity: 10-cycle frame
        start_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        check_frame(11'b00111111111, 10, -1, "ff");
        check_idle("ff");
        tick();
        check_idle("ff+1");

        // Back-to-back 0x3C then 0xC3 with data_valid held high
        start_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        p_data = 8'hC3;
        check_frame(11'b00011110001, 11, -1, "b2b1");
        data_valid = 1'b0;
        chk("b2b2 par_data", par_data, 8'hC3);
        check_frame(11'b01100001101, 11, -1, "b2b2");
        check_idle("b2b");

        // Spurious request and option toggle during DATA
        start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_frame(11'b01010010101, 11, 3, "pulse");
        check_idle("pulse");
        chk("pulse par_data", par_data, 8'hA5);
        chk("pulse par_enable", par_enable, 1'b1);
        chk("pulse par_type", par_type, 1'b0);
        tick();
        check_idle("pulse+1");
        par_en  = 1'b1;
        par_typ = 1'b0;

        // Reset during DATA bit 3 of 0x96 (bit 3 is 0)
        start_frame(8'h96, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        chk("abort pre tx", tx_out, 1'b0);
        chk("abort pre busy", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort tx", tx_out, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort par_data", par_data, 8'h00);
        chk("abort par_enable", par_enable, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_idle("abort");
        tick();
        check_idle("abort+1");

        // Fresh frame after reset: 0x5A even parity
        start_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check_frame(11'b00101101001, 11, -1, "5a");
        check_idle("5a");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the number of payload bits per frame (minimum 2).
REQ-002 SHALL have `clk`, input, 1 bit: system clock, all state updates on the rising edge.
REQ-003 SHALL have `rst`, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have `p_data`, input, DATA_WIDTH bits: parallel payload to transmit.
REQ-005 SHALL have `data_valid`, input, 1 bit: payload request, qualifies `p_data`.
REQ-006 SHALL have `par_en`, input, 1 bit: 1 inserts a parity bit into the frame.
REQ-007 SHALL have `par_typ`, input, 1 bit: parity type, 0 = even, 1 = odd.
REQ-008 SHALL have `par_bit`, input, 1 bit: computed parity returned by the parity calculator.
REQ-009 SHALL have `par_data`, output, DATA_WIDTH bits: latched payload driven to the parity calculator.
REQ-010 SHALL have `par_data_valid`, output, 1 bit: single-cycle load strobe to the parity calculator.
REQ-011 SHALL have `par_enable`, output, 1 bit: latched `par_en`, driven to the parity calculator.
REQ-012 SHALL have `par_type`, output, 1 bit: latched `par_typ`, driven to the parity calculator.
REQ-013 SHALL have `tx_out`, output, 1 bit: serial line, idle high.
REQ-014 SHALL have `busy`, output, 1 bit: 1 while a frame is in progress.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL accept a payload on a rising edge where the state is IDLE and `data_valid` is 1.
- On acceptance: `p_data` is latched into the shift and `par_data` registers, `par_en` into `par_enable`, `par_typ` into `par_type`, and the state moves to START.
REQ-017 SHALL ignore `data_valid` in START, DATA and PARITY; there is no queuing and latched values do not change.
REQ-018 SHALL decode `tx_out` from the current state only.
- IDLE = 1, START = 0, DATA = current shift-register bit (LSB first), PARITY = `par_bit`, STOP = 1.
REQ-019 SHALL drive `busy` = 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-020 SHALL assert `par_data_valid` for exactly one cycle, during the START cycle, from a register, so the parity result is valid before PARITY.
REQ-021 SHALL always move START -> DATA after one cycle.
REQ-022 SHALL hold DATA for exactly DATA_WIDTH cycles.
- A bit counter runs 0..DATA_WIDTH-1 and the shift register shifts right once per DATA cycle.
- The counter clears on DATA exit.
REQ-023 SHALL leave DATA after the last bit to PARITY when `par_enable` = 1, otherwise to STOP.
REQ-024 SHALL hold PARITY for one cycle, then move to STOP.
REQ-025 SHALL hold STOP for one cycle.
- If `data_valid` = 1 on the STOP exit edge, the new payload is accepted per REQ-016 and the state goes directly to START (back-to-back, no idle cycle).
- Otherwise the state goes to IDLE.
REQ-026 SHALL make a frame last DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 cycles without.
REQ-027 SHALL keep `par_enable` and `par_type` constant from acceptance until the next acceptance, ignoring changes on `par_en` and `par_typ` mid-frame.
REQ-028 SHALL treat `data_valid` held high continuously as a new frame request at each STOP exit.

Reset
REQ-029 SHALL, while `rst` = 0 and independent of `clk`, force the following immediately, including mid-frame:
- state = IDLE, bit counter = 0, shift register = 0, `par_data` = 0
- `par_data_valid` = 0, `par_enable` = 0, `par_type` = 0
- `tx_out` = 1, `busy` = 0
REQ-030 SHALL resume from IDLE after `rst` release; an aborted frame is not resumed.

Verification
REQ-031 SHALL pass: `p_data` = 0xA5, `par_en` = 1, `par_typ` = 0 -> `tx_out` = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, `busy` high for 11 cycles, `par_data_valid` high only in cycle 1.
REQ-032 SHALL pass: `p_data` = 0x01, `par_en` = 1, `par_typ` = 1 -> parity-slot `tx_out` = 0; `p_data` = 0x00 with odd parity -> parity-slot `tx_out` = 1.
REQ-033 SHALL pass: `p_data` = 0xFF, `par_en` = 0 -> `tx_out` = 0,1,1,1,1,1,1,1,1,1 over 10 cycles, then IDLE with `tx_out` = 1.
REQ-034 SHALL pass: `data_valid` held high with 0x3C then 0xC3 -> second START immediately follows the first STOP, no idle cycle, and each frame is correct.
REQ-035 SHALL pass: `data_valid` pulsed during DATA, and `par_en` toggled mid-frame -> the frame in progress is unchanged, and the pulsed payload is never sent.
REQ-036 SHALL pass: `rst` asserted at DATA bit 3 -> same-cycle `tx_out` = 1 and `busy` = 0; after release, a new 0x5A frame transmits correctly.
